uart_rx: RTL

//  Serial receiver that consumes the line driven by uart_tx (8N1 or 8E1, LSB first, idle high).

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_sync.sv | 14 +
 rtl/uart_rx.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and parity modes
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam logic PARITY_NONE = 1'b0;
  localparam logic PARITY_EVEN = 1'b1;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser with parameterised reset value
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [1:0] ff;
  always_ff @(posedge sysclk)
    ff <= !reset_n ? {2{RST_VAL}} : {ff[0], d};
  assign q = ff[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8E1 serial receiver with mid-bit sampling, parity and framing checks
module uart_rx
  import uart_pkg::*;
#(
  parameter int N       = 8,
  parameter int PSCALER = 1,
  parameter int DIV     = 10
) (
  input  logic         sysclk,
  input  logic         reset_n,
  input  logic         parity_i,
  input  logic         rx_i,
  output logic [N-1:0] rx_data_o,
  output logic         rx_valid_o,
  output logic         rx_parity_err_o,
  output logic         rx_frame_err_o,
  output logic         rx_busy_o
);
  localparam int BIT_CYC = PSCALER * DIV;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int BW      = $clog2(N + 1);
  rx_state_t      state;
  logic           rx_s, rx_q, par_mode, par_err, stop_bit, done, fin;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bits;
  logic [N-1:0]   shift;
  logic           tick_half, tick_full;
  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .d      (rx_i),
    .q      (rx_s)
  );
  assign tick_half = cnt == CW'(BIT_CYC / 2 - 1);
  assign tick_full = cnt == CW'(BIT_CYC - 1);
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state           <= IDLE;
      rx_q            <= 1'b1;
      cnt             <= '0;
      bits            <= '0;
      shift           <= '0;
      par_mode        <= PARITY_NONE;
      par_err         <= 1'b0;
      stop_bit        <= 1'b1;
      done            <= 1'b0;
      fin             <= 1'b0;
      rx_data_o       <= '0;
      rx_valid_o      <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_busy_o       <= 1'b0;
    end else begin
      rx_q       <= rx_s;
      rx_valid_o <= fin;
      fin        <= 1'b0;
      if (fin) begin
        rx_data_o       <= shift;
        rx_parity_err_o <= par_err;
        rx_frame_err_o  <= !stop_bit;
      end
      case (state)
        IDLE: if (rx_q && !rx_s) begin
          state     <= START;
          cnt       <= '0;
          bits      <= BW'(N);
          par_mode  <= parity_i;
          par_err   <= 1'b0;
          rx_busy_o <= 1'b1;
        end
        START: if (tick_half) begin
          cnt       <= '0;
          state     <= rx_s ? IDLE : DATA;
          rx_busy_o <= !rx_s;
        end else cnt <= cnt + 1'b1;
        DATA: if (tick_full) begin
          cnt   <= '0;
          shift <= (shift >> 1) | (N'(rx_s) << (N - 1));
          bits  <= bits - 1'b1;
          if (bits == BW'(1)) state <= (par_mode == PARITY_EVEN) ? PARITY : STOP;
        end else cnt <= cnt + 1'b1;
        PARITY: if (tick_full) begin
          cnt     <= '0;
          par_err <= rx_s != ^shift;
          state   <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (done) begin
          if (stop_bit || rx_s) begin
            state     <= IDLE;
            done      <= 1'b0;
            rx_busy_o <= 1'b0;
          end
        end else if (tick_full) begin
          cnt      <= '0;
          stop_bit <= rx_s;
          done     <= 1'b1;
          fin      <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
